bclvds_en_seq: RTL and testbench

Sequencer that drives the bank-controller LVDS output-enable (`LVDSENI`) of one I/O bank on behalf of the DDR3 PHY. It turns the bank's LVDS drivers on when a client requests them, waits a settle time before granting, and powers them down after an idle period. It sits between the controller's output-path logic and the per-bank LVDS output-enable primitive, one instance per bank.

---
 rtl/bclvds_pkg.sv | 19 +
 rtl/bclvds_seq_timer.sv | 30 +++
 rtl/bclvds_en_seq.sv | 125 ++++++++++++
 tb/tb_bclvds_en_seq.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/bclvds_pkg.sv
// Shared definitions for the bank-controller LVDS output-enable sequencer:
// state encoding, timer width and the counter reload helper.
package bclvds_pkg;

    localparam int BCLVDS_CNT_W = 16;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        SETTLE = 2'd1,
        ON     = 2'd2,
        COOL   = 2'd3
    } bclvds_state_e;

    // A phase of N cycles reloads the down-counter with N-1.
    function automatic logic [BCLVDS_CNT_W-1:0] cnt_load(input int cycles);
        return BCLVDS_CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/bclvds_seq_timer.sv
// Loadable saturating down-counter shared by all timed sequencer states.
module bclvds_seq_timer
    import bclvds_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [BCLVDS_CNT_W-1:0] load_val,
    input  logic                    dec,
    output logic                    zero
);

    logic [BCLVDS_CNT_W-1:0] cnt_r;

    // Load has priority; decrement stops at zero so the count never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {BCLVDS_CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != {BCLVDS_CNT_W{1'b0}})) begin
            cnt_r <= cnt_r - BCLVDS_CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {BCLVDS_CNT_W{1'b0}});

endmodule

// File: rtl/bclvds_en_seq.sv
// Per-bank LVDS output-enable sequencer: power-up, settle, grant, idle power-down.
// Idle power-down (ON -> COOL -> OFF) exists only when BCLVDS_IDLE_OFF_EN is defined.
module bclvds_en_seq
    import bclvds_pkg::*;
#(
    parameter int BANKID         = 2,
    parameter int SETTLE_CYCLES  = 16,
    parameter int IDLE_CYCLES    = 256,
    parameter int MIN_OFF_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    output logic       ack,
    output logic       lvds_en,
    output logic       busy,
    output logic [1:0] state
);

    localparam logic [BCLVDS_CNT_W-1:0] SETTLE_LOAD = cnt_load(SETTLE_CYCLES);

    if ((BANKID < 0) ||
        (SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 65535) ||
        (IDLE_CYCLES < 1) || (IDLE_CYCLES > 65535) ||
        (MIN_OFF_CYCLES < 1) || (MIN_OFF_CYCLES > 65535)) begin : g_param_range
        $error("bclvds_en_seq: timing parameter out of range 1..65535");
    end

`ifdef BCLVDS_IDLE_OFF_EN
    localparam logic [BCLVDS_CNT_W-1:0] IDLE_LOAD    = cnt_load(IDLE_CYCLES);
    localparam logic [BCLVDS_CNT_W-1:0] MIN_OFF_LOAD = cnt_load(MIN_OFF_CYCLES);
`endif

    bclvds_state_e           state_r;
    bclvds_state_e           next_s;
    logic                    load_s;
    logic [BCLVDS_CNT_W-1:0] load_val_s;
    logic                    dec_s;
    logic                    zero_s;

    bclvds_seq_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .load_val (load_val_s),
        .dec      (dec_s),
        .zero     (zero_s)
    );

    // Next-state and timer control; a request landing as COOL expires still passes through OFF.
    always_comb begin
        next_s     = state_r;
        load_s     = 1'b0;
        load_val_s = SETTLE_LOAD;
        dec_s      = 1'b0;
        case (state_r)
            OFF: begin
                if (req) begin
                    next_s     = SETTLE;
                    load_s     = 1'b1;
                    load_val_s = SETTLE_LOAD;
                end else begin
                    next_s = OFF;
                end
            end
            SETTLE: begin
                if (zero_s) begin
                    next_s = ON;
`ifdef BCLVDS_IDLE_OFF_EN
                    load_s     = 1'b1;
                    load_val_s = IDLE_LOAD;
`endif
                end else begin
                    dec_s = 1'b1;
                end
            end
            ON: begin
`ifdef BCLVDS_IDLE_OFF_EN
                if (req) begin
                    load_s     = 1'b1;
                    load_val_s = IDLE_LOAD;
                end else if (zero_s) begin
                    next_s     = COOL;
                    load_s     = 1'b1;
                    load_val_s = MIN_OFF_LOAD;
                end else begin
                    dec_s = 1'b1;
                end
`else
                next_s = ON;
`endif
            end
`ifdef BCLVDS_IDLE_OFF_EN
            COOL: begin
                if (zero_s) begin
                    next_s = OFF;
                end else begin
                    dec_s = 1'b1;
                end
            end
`endif
            default: begin
                next_s = OFF;
            end
        endcase
    end

    // State register with outputs decoded from next-state so none depend on req combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= OFF;
            state   <= 2'd0;
            lvds_en <= 1'b0;
            ack     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_r <= next_s;
            state   <= next_s;
            lvds_en <= (next_s == SETTLE) || (next_s == ON);
            ack     <= (next_s == ON);
            busy    <= (next_s == SETTLE) || (next_s == COOL);
        end
    end

endmodule

// File: tb/tb_bclvds_en_seq.sv
// Self-checking bench for bclvds_en_seq; idle power-down scenarios run when
// BCLVDS_IDLE_OFF_EN is defined, the terminal-ON scenario otherwise.
module tb_bclvds_en_seq;

    localparam logic [1:0] S_OFF    = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_ON     = 2'd2;
    localparam logic [1:0] S_COOL   = 2'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic       ack;
    logic       lvds_en;
    logic       busy;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard of {state, busy, ack, lvds_en}.
    logic [4:0] exp_q[$];
    logic [4:0] got;
    logic [4:0] want;

    bclvds_en_seq #(
        .BANKID         (2),
        .SETTLE_CYCLES  (16),
        .IDLE_CYCLES    (256),
        .MIN_OFF_CYCLES (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .ack     (ack),
        .lvds_en (lvds_en),
        .busy    (busy),
        .state   (state)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] exp_of(input logic [1:0] st);
        return {st, (st == S_SETTLE) || (st == S_COOL), st == S_ON,
                (st == S_SETTLE) || (st == S_ON)};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back(exp_of(S_OFF));
        got = {state, busy, ack, lvds_en}; want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_fail++; $display("FAIL reset_hold got=%b want=%b", got, want);
        end
        rst = 1'b0;
        for (int k = 0; k < 50; k++) begin
            exp_q.push_back(exp_of(S_OFF));
            req = 1'b0;
            @(posedge clk); #1;
            got = {state, busy, ack, lvds_en}; want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++; $display("FAIL reset_idle k=%0d got=%b want=%b", k, got, want);
            end
        end
    endtask

    // req rises before edge 10 and stays high: SETTLE after edges 10..25, ON from 26.
    task automatic test_settle();
        logic [1:0] st;
        for (int k = 0; k < 36; k++) begin
            if (k < 10)      st = S_OFF;
            else if (k < 26) st = S_SETTLE;
            else             st = S_ON;
            exp_q.push_back(exp_of(st));
            req = (k >= 10);
            @(posedge clk); #1;
            got = {state, busy, ack, lvds_en}; want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++; $display("FAIL settle k=%0d got=%b want=%b", k, got, want);
            end
        end
    endtask

`ifdef BCLVDS_IDLE_OFF_EN
    // 200 low, 1 high (edge 200), then low: COOL only after the 256th further low edge.
    task automatic test_idle();
        for (int k = 0; k <= 456; k++) begin
            exp_q.push_back(exp_of((k < 456) ? S_ON : S_COOL));
            req = (k == 200);
            @(posedge clk); #1;
            got = {state, busy, ack, lvds_en}; want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++; $display("FAIL idle k=%0d got=%b want=%b", k, got, want);
            end
        end
    endtask

    // req high right after power-down: 7 more COOL edges, one OFF, then SETTLE x16, ON.
    task automatic test_min_off();
        logic [1:0] st;
        for (int j = 0; j < 30; j++) begin
            if (j < 7)       st = S_COOL;
            else if (j == 7) st = S_OFF;
            else if (j < 24) st = S_SETTLE;
            else             st = S_ON;
            exp_q.push_back(exp_of(st));
            req = 1'b1;
            @(posedge clk); #1;
            got = {state, busy, ack, lvds_en}; want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++; $display("FAIL min_off j=%0d got=%b want=%b", j, got, want);
            end
        end
    endtask
`else
    // ON is terminal: long req-low stretch must not power down.
    task automatic test_no_idle_off();
        for (int k = 0; k < 1000; k++) begin
            exp_q.push_back(exp_of(S_ON));
            req = 1'b0;
            @(posedge clk); #1;
            got = {state, busy, ack, lvds_en}; want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++; $display("FAIL no_idle_off k=%0d got=%b want=%b", k, got, want);
            end
        end
    endtask
`endif

    // Async reset mid-SETTLE kills the drivers at once; the full settle repeats afterwards.
    task automatic test_rst_mid_settle();
        rst = 1'b1;
        req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(exp_of(S_SETTLE));
            req = 1'b1;
            @(posedge clk); #1;
            got = {state, busy, ack, lvds_en}; want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++; $display("FAIL rst_pre k=%0d got=%b want=%b", k, got, want);
            end
        end
        #2;
        exp_q.push_back(exp_of(S_OFF));
        rst = 1'b1;
        #1;
        got = {state, busy, ack, lvds_en}; want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_fail++; $display("FAIL rst_async got=%b want=%b", got, want);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            exp_q.push_back(exp_of((k < 16) ? S_SETTLE : S_ON));
            req = 1'b1;
            @(posedge clk); #1;
            got = {state, busy, ack, lvds_en}; want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++; $display("FAIL rst_resettle k=%0d got=%b want=%b", k, got, want);
            end
        end
    endtask

    // One-cycle req pulse: SETTLE still runs to completion.
    task automatic test_req_drop_in_settle();
        rst = 1'b1;
        req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            exp_q.push_back(exp_of((k < 16) ? S_SETTLE : S_ON));
            req = (k == 0);
            @(posedge clk); #1;
            got = {state, busy, ack, lvds_en}; want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++; $display("FAIL req_drop k=%0d got=%b want=%b", k, got, want);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_settle();
`ifdef BCLVDS_IDLE_OFF_EN
        test_idle();
        test_min_off();
`else
        test_no_idle_off();
`endif
        test_rst_mid_settle();
        test_req_drop_in_settle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
